// File: rtl/snn_pkg.sv
// Shared definitions for the spike decoding path: FSM encoding, default
// widths and a saturating increment helper.
package snn_pkg;

    localparam int CNT_W_DEF = 7;
    localparam int WIN_W_DEF = 8;
    localparam int ISI_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Add inc to v, sticking at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic        inc,
                                            input logic [31:0] max);
        if (inc && (v < max))
            return v + 32'd1;
        return v;
    endfunction

endpackage

// File: rtl/snn_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module snn_sat_counter
    import snn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX = '1;

    assign at_max = (value == MAX);

    // Clear or saturating increment.
    always_ff @(posedge clk) begin
        if (reset || clr)
            value <= '0;
        else
            value <= WIDTH'(sat_inc(32'(value), inc, 32'(MAX)));
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges over back-to-back windows of programmable
// length and measures the interval between consecutive rises.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int ISI_W = ISI_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_next;
    logic             spike_d;
    logic             rise;
    logic             run_act;
    logic             win_last;
    logic             armed;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] count, count_next;
    logic             count_at_max;
    logic [ISI_W-1:0] isi_cnt, isi_next;
    logic             isi_at_max;

    assign rise     = spike_in & ~spike_d;
    // Aborting (enable low in RUN) counts as not running for this cycle.
    assign run_act  = (state == ST_RUN) & enable;
    assign win_last = run_act & (win_cnt == '0);

    // Values the counters reach at this edge; published on window close / rise.
    assign count_next = count_at_max ? count : count + CNT_W'(rise);
    assign isi_next   = isi_at_max ? isi_cnt : isi_cnt + ISI_W'(1);

    // Rise count of the open window; cleared at window close and when not running.
    snn_sat_counter #(.WIDTH(CNT_W)) u_count (
        .clk    (clk),
        .reset  (reset),
        .clr    (~run_act | win_last),
        .inc    (rise),
        .value  (count),
        .at_max (count_at_max)
    );

    // Cycles since the last rise; restarts on every rise.
    snn_sat_counter #(.WIDTH(ISI_W)) u_isi (
        .clk    (clk),
        .reset  (reset),
        .clr    (~run_act | rise),
        .inc    (1'b1),
        .value  (isi_cnt),
        .at_max (isi_at_max)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable)  state_next = ST_RUN;
            ST_RUN:  if (!enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state == ST_RUN);
    end

    // Edge-detect history, tracked in every state.
    always_ff @(posedge clk) begin
        if (reset)
            spike_d <= 1'b0;
        else
            spike_d <= spike_in;
    end

    // Window down-counter; window_len 0 wraps to 2**WIN_W-1, i.e. a full-range window.
    always_ff @(posedge clk) begin
        if (reset)
            win_cnt <= '0;
        else if (((state == ST_IDLE) && enable) || win_last)
            win_cnt <= window_len - WIN_W'(1);
        else if (run_act)
            win_cnt <= win_cnt - WIN_W'(1);
    end

    // ISI arming: first rise of a run only starts the measurement.
    always_ff @(posedge clk) begin
        if (reset || !run_act)
            armed <= 1'b0;
        else if (rise)
            armed <= 1'b1;
    end

    // Published results and their valid pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_out   <= '0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
            isi_out    <= '0;
            isi_valid  <= 1'b0;
        end else begin
            rate_valid <= win_last;
            if (win_last) begin
                rate_out <= count_next;
                rate_sat <= (count_next == CNT_MAX);
            end
            isi_valid <= run_act & rise & armed;
            if (run_act && rise && armed)
                isi_out <= isi_next;
        end
    end

endmodule
